mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between three masters: CPU instruction fetch (req 0), CPU load/store (req 1) and the DMA engine (req 2).
- Sits between the CPU/DMA master interfaces and the memory in soc_top.
- Arbitration order: starvation guard first, then optional DMA burst lock, then round-robin.
- Routes read responses back to the issuing master through a latency-matched owner pipeline.

Parameters:
- ADDR_W, 32, address width.
- XLEN, 32, data width.
- MEM_LAT, 1, cycles from memory accept to read data valid (1..4).
- MAX_BURST, 4, maximum consecutive locked DMA grants.
- WAIT_MAX, 8, wait cycles after which a requester is starved.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  3  per-master request; payload held stable until gnt.
- req_addr  in  3*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W].
- req_we  in  3  write enable per master.
- req_wdata  in  3*XLEN  packed write data.
- req_wstrb  in  3*(XLEN/8)  packed byte strobes.
- dma_lock  in  1  DMA requests burst retention.
- gnt  out  3  one-hot grant; request accepted this cycle.
- rvalid  out  3  per-master read-response strobe.
- rdata  out  XLEN  read data, broadcast to all masters.
- mem_req  out  1  memory access valid.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  XLEN  memory write data.
- mem_wstrb  out  XLEN/8  memory byte strobes.
- mem_ready  in  1  memory can accept an access this cycle.
- mem_rdata  in  XLEN  memory read data, valid MEM_LAT cycles after accept.

Behaviour:
- Reset (rst=1 at posedge):
  - Registered state: rvalid=0, last_gnt=2 (so req 0 ranks first), all wait_cnt=0, burst_cnt=0, owner pipeline cleared.
  - Combinational outputs while rst=1: gnt=0, mem_req=0.
- Grant is combinational, same cycle as the request. gnt is at most one-hot, and all gnt bits are 0 when mem_ready=0 or rst=1.
- mem_req = |gnt. mem_addr, mem_we, mem_wdata and mem_wstrb are muxed from the granted master; they are 0 when nothing is granted.
- Winner selection, highest rule first:
  - Starvation: any requester with req=1 and wait_cnt==WAIT_MAX; the lowest index among them wins. Overrides the DMA lock.
  - Lock: DMA wins if last_gnt==2, the previous cycle granted DMA, dma_lock=1, req[2]=1 and burst_cnt<MAX_BURST.
  - Round-robin: the first requester at or after (last_gnt+1) mod 3 with req=1.
- wait_cnt[i]:
  - cleared when req[i]=0 or gnt[i]=1;
  - otherwise +1 per cycle, saturating at WAIT_MAX;
  - increments during mem_ready=0 stalls.
- burst_cnt:
  - on a DMA grant with dma_lock=1: +1 (saturating);
  - on any non-DMA grant, any idle grant cycle, or dma_lock=0: cleared to 0;
  - on reaching MAX_BURST the lock yields and round-robin proceeds from last_gnt=2.
- last_gnt updates only on a grant.
- Owner pipeline:
  - MEM_LAT stages of {valid, id[1:0]}; valid is set only for granted reads (we=0).
  - The stage-MEM_LAT output drives rvalid[id]=1 for one cycle; rdata = mem_rdata combinationally in that cycle.
  - Writes produce no response.
- A new grant is allowed every cycle; reads are fully pipelined with no bubbles.
- Requester drops req without a grant: legal, no side effects.
- Reset mid-operation: in-flight reads are discarded; no rvalid is issued after reset.
- X on unselected payload lanes must not propagate to mem_* outputs.

Test Plan:
1. Single read, MEM_LAT=1: req0 with addr 0x100, mem_rdata=0x00000013 → gnt=3'b001 in cycle T, mem_addr=0x100, rvalid=3'b001 with rdata=0x00000013 at T+1.
2. All three req held high, dma_lock=0, mem_ready=1 → grant sequence 0,1,2,0,1,2; no idle cycle; each master's read returns to the correct rvalid bit.
3. DMA burst: MAX_BURST=4, req2 and req1 high, dma_lock=1, DMA granted first → 4 consecutive DMA grants, then master 1, then DMA again (burst_cnt restarts).
4. Starvation: WAIT_MAX=8, MAX_BURST=16, DMA locked and granted continuously, req1 asserted at cycle T → gnt[1] at T+8 (wait_cnt==8), DMA resumes at T+9.
5. Stall: mem_ready=0 for 3 cycles with req0 high → gnt=0 and mem_req=0 for 3 cycles, wait_cnt[0]=3, gnt[0] in the first cycle mem_ready=1.
6. Write and reset: DMA write sw 0x11111111 to 0x300 → mem_we=1, mem_wstrb=4'hF, no rvalid. Read granted at T, rst=1 at T+1 → rvalid stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the shared memory port.
// Requester side: req/req_addr/req_we/req_wdata/req_wstrb/dma_lock in, gnt/rvalid/rdata out.
// Memory side: mem_req/mem_addr/mem_we/mem_wdata/mem_wstrb out, mem_ready/mem_rdata in.
// master = environment (masters + memory), slave = arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
);
    logic [2:0]            req;
    logic [3*ADDR_W-1:0]   req_addr;
    logic [2:0]            req_we;
    logic [3*XLEN-1:0]     req_wdata;
    logic [3*(XLEN/8)-1:0] req_wstrb;
    logic                  dma_lock;
    logic [2:0]            gnt;
    logic [2:0]            rvalid;
    logic [XLEN-1:0]       rdata;
    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic [XLEN-1:0]       mem_wdata;
    logic [XLEN/8-1:0]     mem_wstrb;
    logic                  mem_ready;
    logic [XLEN-1:0]       mem_rdata;
    modport master (
        output req, req_addr, req_we, req_wdata, req_wstrb, dma_lock, mem_ready, mem_rdata,
        input  gnt, rvalid, rdata, mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb
    );
    modport slave (
        input  req, req_addr, req_we, req_wdata, req_wstrb, dma_lock, mem_ready, mem_rdata,
        output gnt, rvalid, rdata, mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between ifetch (0), load/store (1) and DMA (2).
// Ports: clk, rst (sync, active-high), bus (mem_port_arbiter_if.slave) carrying the
// per-master requests, one-hot gnt, per-master rvalid, broadcast rdata and the memory port.
// Priority: starvation guard, then DMA burst lock, then round-robin after last_gnt.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int XLEN      = 32,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 4,
    parameter int WAIT_MAX  = 8
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int WC_W = $clog2(WAIT_MAX + 1);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam int SW   = XLEN / 8;

    logic [1:0]         last_gnt;
    logic               prev_dma;
    logic [WC_W-1:0]    wait_cnt [3];
    logic [BC_W-1:0]    burst_cnt;
    logic [MEM_LAT-1:0] pipe_vld;
    logic [1:0]         pipe_id [MEM_LAT];
    logic [1:0]         st_id, rr_id, win_id;
    logic               st_any, lock_ok, go;
    logic [2:0]         gnt;

    always_comb begin
        st_any = 1'b0;
        st_id  = 2'd0;
        // descending scan so the lowest starved index is the one left standing
        for (int i = 2; i >= 0; i--)
            if (bus.req[i] && wait_cnt[i] == WC_W'(WAIT_MAX)) begin
                st_any = 1'b1;
                st_id  = 2'(i);
            end
        rr_id = 2'd0;
        // descending offset so the nearest requester after last_gnt wins
        for (int k = 3; k >= 1; k--)
            if (bus.req[2'((int'(last_gnt) + k) % 3)])
                rr_id = 2'((int'(last_gnt) + k) % 3);
        lock_ok = last_gnt == 2'd2 && prev_dma && bus.dma_lock && bus.req[2]
                  && burst_cnt < BC_W'(MAX_BURST);
        win_id  = st_any ? st_id : lock_ok ? 2'd2 : rr_id;
        go      = !rst && bus.mem_ready && |bus.req;
        gnt     = go ? 3'b001 << win_id : 3'b000;
    end

    always_comb begin
        bus.gnt       = gnt;
        bus.mem_req   = go;
        bus.mem_addr  = go ? bus.req_addr[win_id*ADDR_W +: ADDR_W] : '0;
        bus.mem_we    = go && bus.req_we[win_id];
        bus.mem_wdata = go ? bus.req_wdata[win_id*XLEN +: XLEN] : '0;
        bus.mem_wstrb = go ? bus.req_wstrb[win_id*SW +: SW] : '0;
        // gated by rst so a response already in the last stage is suppressed during reset
        bus.rvalid    = (pipe_vld[MEM_LAT-1] && !rst) ? 3'b001 << pipe_id[MEM_LAT-1] : 3'b000;
        bus.rdata     = bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt  <= 2'd2;
            prev_dma  <= 1'b0;
            burst_cnt <= '0;
            pipe_vld  <= '0;
            for (int i = 0; i < 3; i++) wait_cnt[i] <= '0;
            for (int s = 0; s < MEM_LAT; s++) pipe_id[s] <= 2'd0;
        end else begin
            for (int i = 0; i < 3; i++)
                wait_cnt[i] <= (!bus.req[i] || gnt[i]) ? '0 :
                               wait_cnt[i] == WC_W'(WAIT_MAX) ? wait_cnt[i] : wait_cnt[i] + 1'b1;
            burst_cnt <= (gnt[2] && bus.dma_lock) ?
                         (burst_cnt == BC_W'(MAX_BURST) ? burst_cnt : burst_cnt + 1'b1) : '0;
            prev_dma  <= gnt[2];
            if (go) last_gnt <= win_id;
            pipe_vld[0] <= go && !bus.req_we[win_id];
            pipe_id[0]  <= win_id;
            for (int s = 1; s < MEM_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_id[s]  <= pipe_id[s-1];
            end
        end
    end
endmodule
